// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams little-endian bytes into instruction memory while stalling the CPU.
// Optional trailing checksum verification is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             cpu_stall,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH_WORDS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] word_index;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_buf;
    logic             xfer;
    logic             last_byte;
    logic [31:0]      assembled;

    assign xfer      = byte_valid & byte_ready;
    assign last_byte = xfer && (byte_cnt == 2'd3);
    // Bytes shift in from the top so the first one ends up in bits 7:0.
    assign assembled = {byte_data, word_buf[31:8]};

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (num_words == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                byte_ready = 1'b1;
                if (last_byte) state_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (remaining > CNT_W'(1)) begin
                    state_next = COLLECT;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
            CHECK: begin
                byte_ready = 1'b1;
                if (last_byte) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_stall = busy;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
    logic        err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                checksum <= '0;
                err_q    <= 1'b0;
            end
            if (state == WRITE) checksum <= checksum ^ mem_wd;
            if (state == CHECK && last_byte) err_q <= (assembled != checksum);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            mem_addr   <= '0;
            mem_wd     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining  <= (num_words > DEPTH_C) ? DEPTH_C : num_words;
                        word_index <= '0;
                        byte_cnt   <= '0;
                    end
                end
                COLLECT, CHECK: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= assembled;
                    end
                    // Address and data are registered here so they are stable throughout WRITE.
                    if (state == COLLECT && last_byte) begin
                        mem_addr <= 32'(word_index) << 2;
                        mem_wd   <= assembled;
                    end
                end
                WRITE: begin
                    remaining <= remaining - CNT_W'(1);
                    if (word_index != LAST_IDX) word_index <= word_index + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a byte-stream model.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int CNT_W = 11;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wd;
    logic             cpu_stall;
    logic             busy;
    logic             done;
    logic             err;

    imem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_stall(cpu_stall), .busy(busy), .done(done), .err(err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_wd[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_wd.push_back(mem_wd);
            last_we_cyc = cyc;
            chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        chk("stall_eq_busy", {31'd0, cpu_stall}, {31'd0, busy});
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we},     32'd0);
        chk({tag, "_stall"}, {31'd0, cpu_stall},  32'd0);
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
        chk({tag, "_done"},  {31'd0, done},       32'd0);
        chk({tag, "_err"},   {31'd0, err},        32'd0);
        chk({tag, "_addr"},  mem_addr,            32'd0);
        chk({tag, "_wd"},    mem_wd,              32'd0);
    endtask

    task automatic feed(input logic [7:0] d[$], input int gap, input bit noise);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < d.size() && guard < 1000) begin
            if (gap == 1)      byte_valid = (guard % 3) == 0;
            else if (gap == 2) byte_valid = ($urandom % 3) != 0;
            else               byte_valid = 1'b1;
            byte_data = byte_valid ? d[idx] : 8'($urandom);
            if (noise) begin
                start     = ($urandom % 4) == 0;
                num_words = CNT_W'($urandom_range(0, 9));
            end
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        chk("feed_timeout", {31'd0, guard < 1000}, 32'd1);
    endtask

    task automatic pulse_start(input int n, output int sc);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_words = CNT_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        sc    = cyc;
    endtask

    task automatic run_load(input string tag, input int n, input int gap, input bit noise,
                            input logic [7:0] din[$], input logic [31:0] sum_xor);
        logic [7:0]  d[$];
        logic [31:0] w;
        logic [31:0] sum;
        logic [31:0] exp_words[$];
        logic        exp_err;
        int          ne;
        int          sc;
        ne = (n > DEPTH) ? DEPTH : n;
        d  = din;
        while (d.size() < ne * 4) d.push_back(8'($urandom));
        sum = 32'd0;
        for (int i = 0; i < ne; i++) begin
            w = {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
            exp_words.push_back(w);
            sum ^= w;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        w = sum ^ sum_xor;
        if (ne > 0) begin
            d.push_back(w[7:0]);
            d.push_back(w[15:8]);
            d.push_back(w[23:16]);
            d.push_back(w[31:24]);
        end
        exp_err = (ne > 0) && (sum_xor != 32'd0);
`else
        exp_err = 1'b0 & (|sum_xor) & (|sum);
`endif
        got_addr.delete();
        got_wd.delete();
        done_cnt = 0;
        pulse_start(n, sc);
        feed(d, gap, noise);
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_nwrites"}, got_addr.size(), ne);
        for (int i = 0; i < ne && i < got_addr.size(); i++) begin
            chk({tag, "_addr"}, got_addr[i], 32'(i * 4));
            chk({tag, "_data"}, got_wd[i], exp_words[i]);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (ne == 0) chk({tag, "_done_lat0"}, done_cyc, sc);
        else         chk({tag, "_done_lat"}, done_cyc, last_we_cyc + 1);
`endif
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d[$];
        int         sc;
        reset      = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_data  = '0;
        byte_valid = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        d = '{8'h93, 8'h02, 8'hA0, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00, 8'h93, 8'h03, 8'h00, 8'h00};
        run_load("load3", 3, 0, 1'b0, d, 32'd0);
        chk("load3_w0", got_wd.size() > 0 ? got_wd[0] : 32'hX, 32'h00A00293);

        d = {};
        run_load("zero", 0, 0, 1'b0, d, 32'd0);

        d = '{8'h93, 8'h02, 8'hA0, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00};
        run_load("bp", 2, 1, 1'b0, d, 32'd0);

        d = {};
        run_load("clamp", 9, 0, 1'b0, d, 32'd0);
        chk("clamp_last_addr", got_addr.size() > 0 ? got_addr[got_addr.size()-1] : 32'hX, 32'd12);

        d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        run_load("cs_ok", 2, 0, 1'b0, d, 32'd0);
        run_load("cs_bad", 2, 0, 1'b0, d, 32'h00000012);

        // Reset in the middle of the second word.
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        got_addr.delete();
        got_wd.delete();
        pulse_start(3, sc);
        feed(d, 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        chk("midrst_nwrites", got_addr.size(), 1);
        chk("midrst_addr", got_addr.size() > 0 ? got_addr[0] : 32'hX, 32'd0);
        chk("midrst_data", got_wd.size() > 0 ? got_wd[0] : 32'hX, 32'h44332211);
        @(posedge clk);
        #1;
        reset = 1'b0;
        d = {};
        run_load("reload", 2, 2, 1'b0, d, 32'd0);

        for (int it = 0; it < 25; it++) begin
            d = {};
            run_load("rand", $urandom_range(0, 6), $urandom_range(0, 2), 1'b1, d,
                     ($urandom % 2) ? ($urandom | 32'd1) : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
